// File: rtl/dm_reconstruct.sv
// Delta-modulation decoder: maps quantizer codes to odd signed steps, integrates them in a
// saturating (optionally leaky) accumulator, then block-averages and decimates the estimate.
module dm_reconstruct #(
    parameter int CODE_W   = 3,
    parameter int ACC_W    = 16,
    parameter int LEAK_SH  = 0,
    parameter int AVG_LOG2 = 3,
    parameter int SETTLE_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  avg_out,
    output logic              avg_valid,
    output logic              sat_flag
);

    localparam int WIDE_W = ACC_W + 2;
    localparam int SUM_W  = ACC_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int SET_W  = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;

    localparam logic signed [CODE_W+1:0] STEP_OFS = (CODE_W + 2)'((2 ** CODE_W) - 1);
    localparam logic signed [WIDE_W-1:0] ACC_MAX  = {3'b000, {(ACC_W - 1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] ACC_MIN  = {3'b111, {(ACC_W - 1){1'b0}}};
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
    localparam logic [SET_W-1:0]         SET_LAST = SET_W'(SETTLE_N - 1);

    typedef enum logic {
        ST_SETTLE,
        ST_RUN
    } state_e;

    localparam state_e INIT_STATE = (SETTLE_N == 0) ? ST_RUN : ST_SETTLE;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      acc_valid_q, acc_valid_d;
    logic signed [ACC_W-1:0]   avg_q, avg_d;
    logic                      avg_valid_q, avg_valid_d;
    logic                      sat_q, sat_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SET_W-1:0]          settle_q, settle_d;

    logic signed [CODE_W+1:0]  step;
    logic signed [WIDE_W-1:0]  acc_wide, leak_wide, step_wide, acc_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      clip;
    logic signed [SUM_W-1:0]   block_sum;

    always_comb begin
        step      = $signed({1'b0, in_code, 1'b0}) - STEP_OFS;
        step_wide = {{(WIDE_W - CODE_W - 2){step[CODE_W+1]}}, step};
        acc_wide  = {{2{acc_q[ACC_W-1]}}, acc_q};
        if (LEAK_SH > 0) begin
            leak_wide = acc_wide >>> LEAK_SH;
        end else begin
            leak_wide = '0;
        end
        acc_sum = acc_wide - leak_wide + step_wide;
        clip    = 1'b0;
        if (acc_sum > ACC_MAX) begin
            acc_next = ACC_MAX[ACC_W-1:0];
            clip     = 1'b1;
        end else if (acc_sum < ACC_MIN) begin
            acc_next = ACC_MIN[ACC_W-1:0];
            clip     = 1'b1;
        end else begin
            acc_next = acc_sum[ACC_W-1:0];
        end
        block_sum = sum_q + {{AVG_LOG2{acc_next[ACC_W-1]}}, acc_next};
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_valid_d = 1'b0;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        sat_d       = sat_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;

        // clr wins over a coincident sample; avg_out deliberately keeps its last value
        if (clr) begin
            state_d  = INIT_STATE;
            acc_d    = '0;
            sat_d    = 1'b0;
            sum_d    = '0;
            cnt_d    = '0;
            settle_d = '0;
        end else if (in_valid) begin
            acc_d       = acc_next;
            acc_valid_d = 1'b1;
            sat_d       = sat_q | clip;
            case (state_q)
                ST_SETTLE: begin
                    if (settle_q == SET_LAST) begin
                        state_d  = ST_RUN;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        // floor division by N is the top ACC_W bits of the block sum
                        avg_d       = block_sum[SUM_W-1:AVG_LOG2];
                        avg_valid_d = 1'b1;
                        sum_d       = '0;
                        cnt_d       = '0;
                    end else begin
                        sum_d = block_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_STATE;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            sat_q       <= sat_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = acc_valid_q;
    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;
    assign sat_flag  = sat_q;

endmodule
